// File: rtl/tmds_pkg.sv
// -----------------------------------------------------------------------------
// tmds_pkg
// Shared TMDS definitions for the channel encoders and decoders:
//   - the four control tokens and the video guard band codes
//   - the 16-entry TERC4 symbol table (index = decoded nibble)
//   - the receive alignment state enum
//   - helpers: guard band selection per channel, TERC4 lookup, video decode
// -----------------------------------------------------------------------------
package tmds_pkg;

    localparam logic [9:0] CTRL_TOKEN_00 = 10'h354;
    localparam logic [9:0] CTRL_TOKEN_01 = 10'h0AB;
    localparam logic [9:0] CTRL_TOKEN_10 = 10'h154;
    localparam logic [9:0] CTRL_TOKEN_11 = 10'h2AB;

    localparam logic [9:0] GUARD_VIDEO_CH02 = 10'h2CC;
    localparam logic [9:0] GUARD_VIDEO_CH1  = 10'h133;

    // Entry i is the symbol that carries nibble i. Entry 8 equals the
    // channel 0/2 video guard band, so both classifications can hit at once.
    localparam logic [9:0] TERC4_TABLE [16] = '{
        10'h29C, 10'h263, 10'h2E4, 10'h2E2,
        10'h171, 10'h11E, 10'h18E, 10'h13C,
        10'h2CC, 10'h139, 10'h19C, 10'h2C6,
        10'h28E, 10'h271, 10'h163, 10'h2C3
    };

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        HOLDOFF = 2'd1,
        LOCKED  = 2'd2
    } align_state_e;

    // Video guard band code used on a given TMDS channel.
    function automatic logic [9:0] video_guard_code(input int channel);
        return (channel == 1) ? GUARD_VIDEO_CH1 : GUARD_VIDEO_CH02;
    endfunction

    // Returns {hit, nibble}; nibble is 0 when there is no hit.
    function automatic logic [4:0] terc4_lookup(input logic [9:0] sym);
        logic [4:0] result;
        result = 5'b0_0000;
        for (int i = 0; i < 16; i++) begin
            result = (sym == TERC4_TABLE[i]) ? {1'b1, 4'(i)} : result;
        end
        return result;
    endfunction

    // TMDS video decode: undo the optional inversion (bit 9), then undo the
    // XOR (bit 8 = 1) or XNOR (bit 8 = 0) transition chain.
    function automatic logic [7:0] tmds_video_decode(input logic [9:0] sym);
        logic [7:0] q;
        logic [7:0] d;
        q    = sym[9] ? ~sym[7:0] : sym[7:0];
        d[0] = q[0];
        for (int i = 1; i < 8; i++) begin
            d[i] = sym[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
        end
        return d;
    endfunction

endpackage

// File: rtl/tmds_symbol_classifier.sv
// -----------------------------------------------------------------------------
// tmds_symbol_classifier
// Purely combinational classification and decode of one 10-bit TMDS symbol.
// Ports:
//   symbol       in   10  TMDS symbol (bit 0 first on the wire)
//   isControl    out   1  symbol is one of the four control tokens
//   controlBits  out   2  {C1,C0} of the token (00 when not a token)
//   isGuardBand  out   1  symbol is the video guard band code for CHANNEL
//   isTerc4      out   1  symbol is in the TERC4 table
//   terc4Data    out   4  TERC4 nibble (0 when not a TERC4 symbol)
//   videoData    out   8  TMDS video decode of the symbol
// -----------------------------------------------------------------------------
module tmds_symbol_classifier
    import tmds_pkg::*;
#(
    parameter int CHANNEL = 0
) (
    input  logic [9:0] symbol,
    output logic       isControl,
    output logic [1:0] controlBits,
    output logic       isGuardBand,
    output logic       isTerc4,
    output logic [3:0] terc4Data,
    output logic [7:0] videoData
);

    logic [4:0] terc4_hit_s;

    // Control token match and {C1,C0} recovery.
    always_comb begin
        isControl   = 1'b1;
        controlBits = 2'b00;
        case (symbol)
            CTRL_TOKEN_00: controlBits = 2'b00;
            CTRL_TOKEN_01: controlBits = 2'b01;
            CTRL_TOKEN_10: controlBits = 2'b10;
            CTRL_TOKEN_11: controlBits = 2'b11;
            default: begin
                isControl   = 1'b0;
                controlBits = 2'b00;
            end
        endcase
    end

    // TERC4 lookup, guard band match and video byte decode.
    always_comb begin
        terc4_hit_s = terc4_lookup(symbol);
        isTerc4     = terc4_hit_s[4];
        terc4Data   = terc4_hit_s[3:0];
        isGuardBand = (symbol == video_guard_code(CHANNEL));
        videoData   = tmds_video_decode(symbol);
    end

endmodule

// File: rtl/tmds_channel_decoder.sv
// -----------------------------------------------------------------------------
// tmds_channel_decoder
// One TMDS receive channel: word alignment by bitslip requests, then decode of
// control tokens, guard bands, TERC4 and video data with 2 cycles of latency
// (stage 1 registers the symbol and classifies it, stage 2 registers decode).
// Ports:
//   pixelClock   in    1  symbol clock, all logic on the rising edge
//   reset        in    1  synchronous, active-high
//   symbol       in   10  deserialized TMDS symbol
//   bitslip      out   1  one-cycle request to shift deserializer alignment
//   locked       out   1  word alignment acquired
//   dataEnable   out   1  decoded symbol is active video (0 while unlocked)
//   control      out   2  {C1,C0} of the most recent control token
//   videoData    out   8  TMDS-decoded byte
//   isTerc4      out   1  symbol matches a TERC4 code
//   terc4Data    out   4  TERC4 nibble
//   isGuardBand  out   1  symbol is the video guard band for CHANNEL
// -----------------------------------------------------------------------------
module tmds_channel_decoder
    import tmds_pkg::*;
#(
    parameter int CHANNEL          = 0,
    parameter int DVI_MODE         = 0,
    parameter int CONTROL_RUN_LOCK = 64,
    parameter int SEARCH_TIMEOUT   = 4096,
    parameter int SLIP_HOLDOFF     = 16,
    parameter int LOCK_WATCHDOG    = 4096
) (
    input  logic       pixelClock,
    input  logic       reset,
    input  logic [9:0] symbol,
    output logic       bitslip,
    output logic       locked,
    output logic       dataEnable,
    output logic [1:0] control,
    output logic [7:0] videoData,
    output logic       isTerc4,
    output logic [3:0] terc4Data,
    output logic       isGuardBand
);

    localparam int RUN_W  = $clog2(CONTROL_RUN_LOCK + 1);
    localparam int TMO_W  = $clog2(SEARCH_TIMEOUT + 1);
    localparam int HOLD_W = $clog2(SLIP_HOLDOFF + 1);
    localparam int WD_W   = $clog2(LOCK_WATCHDOG + 1);

    // A counter "reaches" its limit on the edge where it would step onto it.
    localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(CONTROL_RUN_LOCK - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(SEARCH_TIMEOUT - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(SLIP_HOLDOFF - 1);
    localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(LOCK_WATCHDOG - 1);

    // Stage 1
    logic [9:0]   s1_symbol_r;
    logic         s1_is_control_s;
    logic [1:0]   s1_control_s;
    logic         s1_is_guard_s;
    logic         s1_is_terc4_s;
    logic [3:0]   s1_terc4_s;
    logic [7:0]   s1_video_s;

    // Alignment FSM
    align_state_e state_r;
    logic [RUN_W-1:0]  run_count_r;
    logic [TMO_W-1:0]  timeout_count_r;
    logic [HOLD_W-1:0] hold_count_r;
    logic [WD_W-1:0]   watchdog_r;
    logic         bitslip_r;
    logic         locked_r;
    logic         lock_hit_s;
    logic         timeout_hit_s;
    logic         hold_done_s;
    logic         watchdog_hit_s;
    logic         locked_next_s;

    // Video period tracking
    logic         guard_seen_r;
    logic         video_armed_r;
    logic         island_r;
    logic         de_s;

    // Stage 2 outputs
    logic         data_enable_r;
    logic [1:0]   control_r;
    logic [7:0]   video_data_r;
    logic         is_terc4_r;
    logic [3:0]   terc4_data_r;
    logic         is_guard_r;

    // Stage 1 symbol register.
    always_ff @(posedge pixelClock) begin
        if (reset) begin
            s1_symbol_r <= 10'h000;
        end else begin
            s1_symbol_r <= symbol;
        end
    end

    tmds_symbol_classifier #(
        .CHANNEL (CHANNEL)
    ) u_classifier (
        .symbol      (s1_symbol_r),
        .isControl   (s1_is_control_s),
        .controlBits (s1_control_s),
        .isGuardBand (s1_is_guard_s),
        .isTerc4     (s1_is_terc4_s),
        .terc4Data   (s1_terc4_s),
        .videoData   (s1_video_s)
    );

    // Limit detection for the FSM counters, and the lock state after this edge.
    // Lock is tested before the timeout so it wins when both hit together.
    always_comb begin
        lock_hit_s     = s1_is_control_s && (run_count_r >= RUN_LAST);
        timeout_hit_s  = (timeout_count_r >= TMO_LAST);
        hold_done_s    = (hold_count_r >= HOLD_LAST);
        watchdog_hit_s = !s1_is_control_s && (watchdog_r >= WD_LAST);
        case (state_r)
            SEARCH:  locked_next_s = lock_hit_s;
            HOLDOFF: locked_next_s = 1'b0;
            LOCKED:  locked_next_s = !watchdog_hit_s;
            default: locked_next_s = 1'b0;
        endcase
    end

    // Alignment FSM: run/timeout/holdoff/watchdog counters, bitslip and lock.
    always_ff @(posedge pixelClock) begin
        if (reset) begin
            state_r         <= SEARCH;
            run_count_r     <= '0;
            timeout_count_r <= '0;
            hold_count_r    <= '0;
            watchdog_r      <= '0;
            bitslip_r       <= 1'b0;
            locked_r        <= 1'b0;
        end else begin
            bitslip_r <= 1'b0;
            case (state_r)
                SEARCH: begin
                    hold_count_r <= '0;
                    watchdog_r   <= '0;
                    if (lock_hit_s) begin
                        state_r         <= LOCKED;
                        locked_r        <= 1'b1;
                        run_count_r     <= '0;
                        timeout_count_r <= '0;
                    end else if (timeout_hit_s) begin
                        state_r         <= HOLDOFF;
                        bitslip_r       <= 1'b1;
                        run_count_r     <= '0;
                        timeout_count_r <= '0;
                    end else begin
                        run_count_r     <= !s1_is_control_s ? '0 :
                                           (run_count_r < RUN_LAST) ? run_count_r + RUN_W'(1) : run_count_r;
                        timeout_count_r <= (timeout_count_r < TMO_LAST) ?
                                           timeout_count_r + TMO_W'(1) : timeout_count_r;
                    end
                end
                HOLDOFF: begin
                    run_count_r     <= '0;
                    timeout_count_r <= '0;
                    watchdog_r      <= '0;
                    if (hold_done_s) begin
                        state_r      <= SEARCH;
                        hold_count_r <= '0;
                    end else begin
                        hold_count_r <= hold_count_r + HOLD_W'(1);
                    end
                end
                LOCKED: begin
                    run_count_r     <= '0;
                    timeout_count_r <= '0;
                    hold_count_r    <= '0;
                    if (s1_is_control_s) begin
                        watchdog_r <= '0;
                    end else if (watchdog_hit_s) begin
                        state_r    <= SEARCH;
                        locked_r   <= 1'b0;
                        watchdog_r <= '0;
                    end else begin
                        watchdog_r <= watchdog_r + WD_W'(1);
                    end
                end
                default: begin
                    state_r         <= SEARCH;
                    run_count_r     <= '0;
                    timeout_count_r <= '0;
                    hold_count_r    <= '0;
                    watchdog_r      <= '0;
                    locked_r        <= 1'b0;
                end
            endcase
        end
    end

    // Video period tracking: after a control token, two guard bands arm the
    // period; any other non-control symbol first marks a data island instead.
    always_ff @(posedge pixelClock) begin
        if (reset || s1_is_control_s) begin
            guard_seen_r  <= 1'b0;
            video_armed_r <= 1'b0;
            island_r      <= 1'b0;
        end else if (!video_armed_r && !island_r) begin
            if (s1_is_guard_s) begin
                guard_seen_r  <= 1'b1;
                video_armed_r <= guard_seen_r;
            end else begin
                island_r <= 1'b1;
            end
        end
    end

    // Active-video qualifier for the symbol in stage 1.
    always_comb begin
        if (DVI_MODE != 0) begin
            de_s = !s1_is_control_s;
        end else begin
            de_s = !s1_is_control_s && video_armed_r;
        end
    end

    // Stage 2 output registers.
    always_ff @(posedge pixelClock) begin
        if (reset) begin
            data_enable_r <= 1'b0;
            control_r     <= 2'b00;
            video_data_r  <= 8'h00;
            is_terc4_r    <= 1'b0;
            terc4_data_r  <= 4'h0;
            is_guard_r    <= 1'b0;
        end else begin
            data_enable_r <= de_s && locked_next_s;
            control_r     <= s1_is_control_s ? s1_control_s : control_r;
            video_data_r  <= s1_video_s;
            is_terc4_r    <= s1_is_terc4_s;
            terc4_data_r  <= s1_terc4_s;
            is_guard_r    <= s1_is_guard_s;
        end
    end

    assign bitslip     = bitslip_r;
    assign locked      = locked_r;
    assign dataEnable  = data_enable_r;
    assign control     = control_r;
    assign videoData   = video_data_r;
    assign isTerc4     = is_terc4_r;
    assign terc4Data   = terc4_data_r;
    assign isGuardBand = is_guard_r;

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// -----------------------------------------------------------------------------
// tb_tmds_channel_decoder
// Directed bench for tmds_channel_decoder (CHANNEL 0, HDMI mode, default
// thresholds). The bench models the deserializer as a rotation of the
// transmitted token that steps back by one bit on every bitslip pulse.
// -----------------------------------------------------------------------------
module tb_tmds_channel_decoder;

    logic       pixelClock = 1'b0;
    logic       reset      = 1'b1;
    logic [9:0] symbol     = 10'h000;
    logic       bitslip;
    logic       locked;
    logic       dataEnable;
    logic [1:0] control;
    logic [7:0] videoData;
    logic       isTerc4;
    logic [3:0] terc4Data;
    logic       isGuardBand;

    int n_cmp       = 0;
    int n_err       = 0;
    int total_slips = 0;

    tmds_channel_decoder dut (
        .pixelClock  (pixelClock),
        .reset       (reset),
        .symbol      (symbol),
        .bitslip     (bitslip),
        .locked      (locked),
        .dataEnable  (dataEnable),
        .control     (control),
        .videoData   (videoData),
        .isTerc4     (isTerc4),
        .terc4Data   (terc4Data),
        .isGuardBand (isGuardBand)
    );

    always #5 pixelClock = ~pixelClock;

    // Drive one symbol, let one rising edge pass, sample 1 time unit later.
    task automatic tick(input logic [9:0] sym);
        symbol = sym;
        @(posedge pixelClock);
        #1;
        if (bitslip) total_slips++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string ctx);
        chk({ctx, "_bitslip"},     32'(bitslip),     32'd0);
        chk({ctx, "_locked"},      32'(locked),      32'd0);
        chk({ctx, "_dataEnable"},  32'(dataEnable),  32'd0);
        chk({ctx, "_control"},     32'(control),     32'd0);
        chk({ctx, "_videoData"},   32'(videoData),   32'd0);
        chk({ctx, "_isTerc4"},     32'(isTerc4),     32'd0);
        chk({ctx, "_terc4Data"},   32'(terc4Data),   32'd0);
        chk({ctx, "_isGuardBand"}, 32'(isGuardBand), 32'd0);
    endtask

    function automatic logic [9:0] rotr(input logic [9:0] v, input int n);
        logic [9:0] r;
        r = v;
        for (int i = 0; i < n; i++) r = {r[0], r[9:1]};
        return r;
    endfunction

    initial begin
        int slips_before;
        int rot;
        int slip_t [3];
        int lock_t;
        int wait_n;
        logic found;

        // ---------------- Reset values ----------------
        reset = 1'b1;
        tick(10'h354);
        tick(10'h354);
        check_reset("reset");

        // ---------------- Lock on 64 aligned control tokens ----------------
        reset = 1'b0;
        slips_before = total_slips;
        for (int i = 0; i < 64; i++) tick(10'h354);
        chk("lock_before_64th_out", 32'(locked), 32'd0);
        tick(10'h354);
        chk("lock_at_64th_out", 32'(locked), 32'd1);
        chk("lock_control00", 32'(control), 32'd0);
        chk("lock_de_on_ctrl", 32'(dataEnable), 32'd0);
        chk("lock_no_slip", 32'(total_slips - slips_before), 32'd0);

        // ---------------- Rotated by 3: three bitslips, then lock ----------
        reset = 1'b1;
        tick(10'h000);
        reset = 1'b0;
        rot = 3;
        lock_t = -1;
        slip_t[0] = -1; slip_t[1] = -1; slip_t[2] = -1;
        slips_before = total_slips;
        for (int t = 1; t <= 13000 && lock_t < 0; t++) begin
            int seen;
            seen = total_slips;
            tick(rotr(10'h354, rot));
            if (total_slips != seen) begin
                if (total_slips - slips_before <= 3) slip_t[total_slips - slips_before - 1] = t;
                if (rot > 0) rot--;
            end
            if (locked) lock_t = t;
        end
        // Pulses every SEARCH_TIMEOUT+SLIP_HOLDOFF cycles from 4096; lock 16+64 after the last.
        chk("slip_count", 32'(total_slips - slips_before), 32'd3);
        chk("slip1_cycle", 32'(slip_t[0]), 32'd4096);
        chk("slip2_cycle", 32'(slip_t[1]), 32'd8208);
        chk("slip3_cycle", 32'(slip_t[2]), 32'd12320);
        chk("relock_cycle", 32'(lock_t), 32'd12400);

        // ---------------- Video period: 0x154, guard, guard, 0xA5 ----------
        tick(10'h154);
        tick(10'h2CC);
        chk("vid_control10", 32'(control), 32'd2);
        chk("vid_de_ctrl", 32'(dataEnable), 32'd0);
        tick(10'h2CC);
        chk("vid_guard1", 32'(isGuardBand), 32'd1);
        chk("vid_de_guard1", 32'(dataEnable), 32'd0);
        tick(10'h163);
        chk("vid_de_guard2", 32'(dataEnable), 32'd0);
        tick(10'h354);
        chk("vid_de_byte", 32'(dataEnable), 32'd1);
        chk("vid_byte_A5", 32'(videoData), 32'hA5);
        chk("vid_control_held", 32'(control), 32'd2);
        chk("vid_guard_off", 32'(isGuardBand), 32'd0);
        tick(10'h0AB);
        chk("vid_de_end", 32'(dataEnable), 32'd0);
        chk("vid_control00", 32'(control), 32'd0);

        // ---------------- Data island: TERC4 0x29C then 0x2CC --------------
        tick(10'h29C);
        chk("isl_control01", 32'(control), 32'd1);
        tick(10'h2CC);
        chk("isl_terc4_hit0", 32'(isTerc4), 32'd1);
        chk("isl_terc4_val0", 32'(terc4Data), 32'd0);
        chk("isl_guard0", 32'(isGuardBand), 32'd0);
        chk("isl_de0", 32'(dataEnable), 32'd0);
        tick(10'h2AB);
        chk("isl_terc4_hit8", 32'(isTerc4), 32'd1);
        chk("isl_terc4_val8", 32'(terc4Data), 32'd8);
        chk("isl_guard8", 32'(isGuardBand), 32'd1);
        chk("isl_de8", 32'(dataEnable), 32'd0);
        tick(10'h354);
        chk("isl_control11", 32'(control), 32'd3);
        chk("isl_terc4_off", 32'(isTerc4), 32'd0);

        // ---------------- Watchdog: 4096 symbols with no control token -----
        // Last control token was just sampled; guard, guard, then inverted 0xA5.
        for (int k = 1; k <= 4096; k++) begin
            tick((k <= 2) ? 10'h2CC : 10'h39C);
            if (k == 4) begin
                chk("wd_de_video", 32'(dataEnable), 32'd1);
                chk("wd_byte_inv_A5", 32'(videoData), 32'hA5);
            end
        end
        chk("wd_locked_4095", 32'(locked), 32'd1);
        chk("wd_de_4095", 32'(dataEnable), 32'd1);
        tick(10'h39C);
        chk("wd_locked_4096", 32'(locked), 32'd0);
        chk("wd_de_4096", 32'(dataEnable), 32'd0);
        tick(10'h39C);
        chk("wd_de_after", 32'(dataEnable), 32'd0);

        // ---------------- Reset during HOLDOFF, then relock ----------------
        // SEARCH began on the watchdog edge; the first bitslip is 4096 edges later.
        found  = 1'b0;
        wait_n = 0;
        slips_before = total_slips;
        for (int t = 1; t <= 4200 && !found; t++) begin
            tick(10'h39C);
            wait_n = t;
            if (total_slips != slips_before) found = 1'b1;
        end
        chk("ho_slip_seen", 32'(found), 32'd1);
        chk("ho_slip_cycle", 32'(wait_n), 32'd4095);
        tick(10'h39C);
        chk("ho_slip_width", 32'(bitslip), 32'd0);
        tick(10'h354);
        reset = 1'b1;
        tick(10'h354);
        check_reset("ho_reset");
        reset = 1'b0;
        slips_before = total_slips;
        for (int i = 0; i < 64; i++) tick(10'h354);
        chk("ho_lock_before", 32'(locked), 32'd0);
        tick(10'h354);
        chk("ho_relock", 32'(locked), 32'd1);
        chk("ho_no_slip", 32'(total_slips - slips_before), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
